// File: rtl/vga_sync_gen_pkg.sv
// Default 640x480@60 timing constants and colour codes shared by
// the sync generator and the card renderers.
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned CLK_DIV   = 2;

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef logic [9:0] cnt_t;
    typedef logic [2:0] rgb_t;

    localparam rgb_t RGB_BLACK = 3'b000;
    localparam rgb_t RGB_RED   = 3'b100;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster bus between the timing generator (master) and the renderers /
// DAC side (slave).
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    cnt_t HCount;
    cnt_t VCount;
    logic video_on;
    logic pixel_tick;
    logic frame_tick;
    logic hsync;
    logic vsync;
    rgb_t rgb_in;
    rgb_t rgb_out;

    modport master (
        output HCount, VCount, video_on, pixel_tick, frame_tick,
        output hsync, vsync, rgb_out,
        input  rgb_in
    );

    modport slave (
        input  HCount, VCount, video_on, pixel_tick, frame_tick,
        input  hsync, vsync, rgb_out,
        output rgb_in
    );

endinterface

// File: rtl/vga_sync_gen_pix_tick_gen.sv
// Board-clock to pixel-rate divider; strobes once every CLK_DIV clocks.
module pix_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pixel_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Gated by reset so a CLK_DIV=1 divider does not strobe while held.
    assign pixel_tick = rst_n && (r_div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counters, sync windows and blanking output stage; sync and
// colour share one register stage so they leave with zero skew.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK,
    parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV
) (
    input logic            clk,
    input logic            rst_n,
    vga_sync_gen_if.master bus
);
    import vga_timing_pkg::*;

    localparam cnt_t H_LAST   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam cnt_t H_VIS    = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS    = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_START = cnt_t'(H_VISIBLE + H_FRONT);
    localparam cnt_t HS_END   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam cnt_t VS_START = cnt_t'(V_VISIBLE + V_FRONT);
    localparam cnt_t VS_END   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

    logic w_pixel_tick;
    logic w_h_last;
    logic w_v_last;
    logic w_video_on;
    logic w_hs_active;
    logic w_vs_active;

    cnt_t r_hcount;
    cnt_t r_vcount;
    logic r_started;
    logic r_hsync;
    logic r_vsync;
    rgb_t r_rgb;

    pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_pix_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .pixel_tick (w_pixel_tick)
    );

    assign w_h_last    = (r_hcount == H_LAST);
    assign w_v_last    = (r_vcount == V_LAST);
    // Blank until the first pixel strobe has moved the counters off reset.
    assign w_video_on  = r_started && (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign w_hs_active = (r_hcount >= HS_START) && (r_hcount < HS_END);
    assign w_vs_active = (r_vcount >= VS_START) && (r_vcount < VS_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcount  <= '0;
            r_vcount  <= '0;
            r_started <= 1'b0;
        end else if (w_pixel_tick) begin
            r_started <= 1'b1;
            if (w_h_last) begin
                r_hcount <= '0;
                r_vcount <= w_v_last ? '0 : r_vcount + 1'b1;
            end else begin
                r_hcount <= r_hcount + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= RGB_BLACK;
        end else begin
            r_hsync <= !w_hs_active;
            r_vsync <= !w_vs_active;
            r_rgb   <= w_video_on ? bus.rgb_in : RGB_BLACK;
        end
    end

    assign bus.HCount     = r_hcount;
    assign bus.VCount     = r_vcount;
    assign bus.video_on   = w_video_on;
    assign bus.pixel_tick = w_pixel_tick;
    assign bus.frame_tick = w_pixel_tick && w_h_last && w_v_last;
    assign bus.hsync      = r_hsync;
    assign bus.vsync      = r_vsync;
    assign bus.rgb_out    = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing (CLK_DIV 2 and 1) plus a shrunken raster
// so whole frames fit in a short run.
module tb_vga_sync_gen;

    localparam int AHT = 800, AVT = 525, AHV = 640, AVV = 480;
    localparam int AHS0 = 656, AHS1 = 752, AVS0 = 490, AVS1 = 492;
    localparam int CHT = 15, CVT = 10, CHV = 8, CVV = 6;
    localparam int CHS0 = 10, CHS1 = 13, CVS0 = 7, CVS1 = 9;

    logic clk;
    logic rst_a, rst_b, rst_c;
    int   n_tests, n_fail;
    int   ka, kb, kc;

    vga_sync_gen_if bus_a ();
    vga_sync_gen_if bus_b ();
    vga_sync_gen_if bus_c ();

    vga_sync_gen #(.CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_a), .bus(bus_a));
    vga_sync_gen #(.CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_b), .bus(bus_b));
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2)
    ) dut_c (.clk(clk), .rst_n(rst_c), .bus(bus_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int mh(int k, int div, int ht);
        return (k / div) % ht;
    endfunction

    function automatic int mv(int k, int div, int ht, int vt);
        return ((k / div) / ht) % vt;
    endfunction

    function automatic logic mvo(int k, int div, int ht, int vt, int hv, int vv);
        return (k >= div) && (mh(k, div, ht) < hv) && (mv(k, div, ht, vt) < vv);
    endfunction

    // Expected {HCount, VCount, pixel_tick, frame_tick, video_on, hsync, vsync, rgb_out}
    // at sample k after reset release; rgb_prev is the colour driven during k-1.
    function automatic logic [27:0] model(int k, int div, int ht, int vt, int hv, int vv,
                                          int hs0, int hs1, int vs0, int vs1,
                                          logic [2:0] rgb_prev);
        int h, v, ph, pv;
        logic pt, ft, vo, hs, vs;
        logic [2:0] rgb;
        h   = mh(k, div, ht);
        v   = mv(k, div, ht, vt);
        pt  = (k % div) == (div - 1);
        ft  = pt && (h == ht - 1) && (v == vt - 1);
        vo  = mvo(k, div, ht, vt, hv, vv);
        hs  = 1'b1;
        vs  = 1'b1;
        rgb = 3'b000;
        if (k > 0) begin
            ph = mh(k - 1, div, ht);
            pv = mv(k - 1, div, ht, vt);
            hs = !(ph >= hs0 && ph < hs1);
            vs = !(pv >= vs0 && pv < vs1);
            if (mvo(k - 1, div, ht, vt, hv, vv)) rgb = rgb_prev;
        end
        return {h[9:0], v[9:0], pt, ft, vo, hs, vs, rgb};
    endfunction

    function automatic logic [27:0] vec_a();
        return {bus_a.HCount, bus_a.VCount, bus_a.pixel_tick, bus_a.frame_tick,
                bus_a.video_on, bus_a.hsync, bus_a.vsync, bus_a.rgb_out};
    endfunction

    function automatic logic [27:0] vec_b();
        return {bus_b.HCount, bus_b.VCount, bus_b.pixel_tick, bus_b.frame_tick,
                bus_b.video_on, bus_b.hsync, bus_b.vsync, bus_b.rgb_out};
    endfunction

    function automatic logic [27:0] vec_c();
        return {bus_c.HCount, bus_c.VCount, bus_c.pixel_tick, bus_c.frame_tick,
                bus_c.video_on, bus_c.hsync, bus_c.vsync, bus_c.rgb_out};
    endfunction

    task automatic test_reset();
        logic [27:0] rv;
        rv = {20'd0, 5'b00011, 3'b000};
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        bus_a.rgb_in = 3'b111; bus_b.rgb_in = 3'b111; bus_c.rgb_in = 3'b111;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (vec_a() !== rv) begin
            n_fail++; $display("FAIL reset_a: got %h required %h", vec_a(), rv);
        end
        n_tests++;
        if (vec_b() !== rv) begin
            n_fail++; $display("FAIL reset_b_div1: got %h required %h", vec_b(), rv);
        end
        n_tests++;
        if (vec_c() !== rv) begin
            n_fail++; $display("FAIL reset_c: got %h required %h", vec_c(), rv);
        end
    endtask

    task automatic test_startup();
        int   h_t [6] = '{0, 0, 1, 1, 2, 2};
        logic [5:0] pt_t = 6'b101010;
        logic [5:0] vo_t = 6'b111100;
        logic [11:0] got, exp;
        rst_a = 1'b1;
        ka = 0;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(negedge clk); #1; ka++;
            end
            got = {bus_a.HCount, bus_a.pixel_tick, bus_a.video_on};
            exp = {h_t[i][9:0], pt_t[i], vo_t[i]};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL startup k=%0d {H,pt,vo}: got %h required %h", i, got, exp);
            end
        end
    endtask

    task automatic test_line();
        logic [27:0] exp;
        int lows;
        lows = 0;
        while (ka < 1700) begin
            @(negedge clk); #1; ka++;
            exp = model(ka, 2, AHT, AVT, AHV, AVV, AHS0, AHS1, AVS0, AVS1, 3'b111);
            n_tests++;
            if (vec_a() !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL line k=%0d: got %h required %h", ka, vec_a(), exp);
            end
            if (!bus_a.hsync) lows++;
            if (ka == 1312 || ka == 1313) begin
                n_tests++;
                if (bus_a.hsync !== (ka == 1312)) begin
                    n_fail++; $display("FAIL hsync_edge k=%0d: got %b required %b", ka, bus_a.hsync, ka == 1312);
                end
            end
            if (ka == 1600) begin
                n_tests++;
                if ({bus_a.HCount, bus_a.VCount} !== {10'd0, 10'd1}) begin
                    n_fail++; $display("FAIL line_wrap: got H=%0d V=%0d required H=0 V=1", bus_a.HCount, bus_a.VCount);
                end
            end
        end
        n_tests++;
        if (lows != 192) begin
            n_fail++; $display("FAIL hsync_width: got %0d clk required 192", lows);
        end
    endtask

    task automatic test_mid_reset();
        logic [27:0] exp, rv;
        int lows;
        rv = {20'd0, 5'b00011, 3'b000};
        lows = 0;
        while (ka < 3000) begin
            @(negedge clk); #1; ka++;
            exp = model(ka, 2, AHT, AVT, AHV, AVV, AHS0, AHS1, AVS0, AVS1, 3'b111);
            n_tests++;
            if (vec_a() !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL pre_reset k=%0d: got %h required %h", ka, vec_a(), exp);
            end
        end
        n_tests++;
        if ({bus_a.HCount, bus_a.hsync} !== {10'd700, 1'b0}) begin
            n_fail++; $display("FAIL in_pulse: got H=%0d hs=%b required H=700 hs=0", bus_a.HCount, bus_a.hsync);
        end
        rst_a = 1'b0;
        #1;
        n_tests++;
        if (vec_a() !== rv) begin
            n_fail++; $display("FAIL reset_immediate: got %h required %h", vec_a(), rv);
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (vec_a() !== rv) begin
            n_fail++; $display("FAIL reset_held: got %h required %h", vec_a(), rv);
        end
        rst_a = 1'b1;
        ka = 0;
        while (ka < 400) begin
            @(negedge clk); #1; ka++;
            exp = model(ka, 2, AHT, AVT, AHV, AVV, AHS0, AHS1, AVS0, AVS1, 3'b111);
            n_tests++;
            if (vec_a() !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL post_reset k=%0d: got %h required %h", ka, vec_a(), exp);
            end
            if (!bus_a.hsync) lows++;
        end
        n_tests++;
        if (lows != 0) begin
            n_fail++; $display("FAIL residual_hsync: got %0d low clk required 0", lows);
        end
    endtask

    task automatic test_rgb();
        logic [27:0] exp;
        logic [2:0]  cur;
        while (ka < 1400) begin
            cur = 3'((ka % 7) + 1);
            bus_a.rgb_in = cur;
            @(negedge clk); #1; ka++;
            exp = model(ka, 2, AHT, AVT, AHV, AVV, AHS0, AHS1, AVS0, AVS1, cur);
            n_tests++;
            if (vec_a() !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL rgb k=%0d: got %h required %h", ka, vec_a(), exp);
            end
            if (ka == 1280) begin
                n_tests++;
                if (bus_a.rgb_out !== cur) begin
                    n_fail++; $display("FAIL rgb_last_visible: got %b required %b", bus_a.rgb_out, cur);
                end
            end
            if (ka == 1282) begin
                n_tests++;
                if (bus_a.rgb_out !== 3'b000) begin
                    n_fail++; $display("FAIL rgb_h640_blank: got %b required 000", bus_a.rgb_out);
                end
            end
        end
        bus_a.rgb_in = 3'b111;
    endtask

    task automatic test_div1();
        logic [27:0] exp;
        int lows;
        lows = 0;
        rst_b = 1'b1;
        kb = 0;
        #1;
        n_tests++;
        exp = model(0, 1, AHT, AVT, AHV, AVV, AHS0, AHS1, AVS0, AVS1, 3'b111);
        if (vec_b() !== exp) begin
            n_fail++; $display("FAIL div1_release: got %h required %h", vec_b(), exp);
        end
        while (kb < 900) begin
            @(negedge clk); #1; kb++;
            exp = model(kb, 1, AHT, AVT, AHV, AVV, AHS0, AHS1, AVS0, AVS1, 3'b111);
            n_tests++;
            if (vec_b() !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL div1 k=%0d: got %h required %h", kb, vec_b(), exp);
            end
            if (!bus_b.hsync) lows++;
            if (kb == 657) begin
                n_tests++;
                if (bus_b.hsync !== 1'b0) begin
                    n_fail++; $display("FAIL div1_hsync_edge: got %b required 0", bus_b.hsync);
                end
            end
            if (kb == 800) begin
                n_tests++;
                if ({bus_b.HCount, bus_b.VCount} !== {10'd0, 10'd1}) begin
                    n_fail++; $display("FAIL div1_line_800: got H=%0d V=%0d required H=0 V=1", bus_b.HCount, bus_b.VCount);
                end
            end
        end
        n_tests++;
        if (lows != 96) begin
            n_fail++; $display("FAIL div1_hsync_width: got %0d clk required 96", lows);
        end
    endtask

    task automatic test_frame();
        logic [27:0] exp;
        int ft_cnt, ft_first, ft_second, vlows;
        ft_cnt = 0; ft_first = -1; ft_second = -1; vlows = 0;
        rst_c = 1'b1;
        kc = 0;
        while (kc < 650) begin
            @(negedge clk); #1; kc++;
            exp = model(kc, 2, CHT, CVT, CHV, CVV, CHS0, CHS1, CVS0, CVS1, 3'b111);
            n_tests++;
            if (vec_c() !== exp) begin
                n_fail++;
                if (n_fail < 20) $display("FAIL frame k=%0d: got %h required %h", kc, vec_c(), exp);
            end
            if (bus_c.frame_tick) begin
                ft_cnt++;
                if (ft_first < 0) ft_first = kc;
                else if (ft_second < 0) ft_second = kc;
            end
            if (kc <= 300 && !bus_c.vsync) vlows++;
            if (kc == 165 || kc == 195) begin
                n_tests++;
                if (bus_c.rgb_out !== ((kc == 165) ? 3'b111 : 3'b000)) begin
                    n_fail++; $display("FAIL rgb_v_boundary k=%0d: got %b required %b", kc, bus_c.rgb_out, (kc == 165) ? 3'b111 : 3'b000);
                end
            end
        end
        n_tests++;
        if ({ft_cnt, ft_first, ft_second} !== {32'd2, 32'd299, 32'd599}) begin
            n_fail++; $display("FAIL frame_tick: got n=%0d at %0d,%0d required n=2 at 299,599", ft_cnt, ft_first, ft_second);
        end
        n_tests++;
        if (vlows != 60) begin
            n_fail++; $display("FAIL vsync_width: got %0d clk required 60", vlows);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_startup();
        test_line();
        test_mid_reset();
        test_rgb();
        test_div1();
        test_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
